// File: rtl/riscv_inst_encoder.sv
// riscv_inst_encoder: packs RV32I instruction fields (R/I/S/B/U/J) into
// 32-bit words, buffers them in a small FIFO and streams them out with
// sequential byte addresses to an instruction-memory loader.
module riscv_inst_encoder #(
  parameter int                FIFO_DEPTH = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [2:0]        in_func3,
  input  logic [6:0]        in_func7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5
  } inst_type_e;

  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic [ADDR_W-1:0] r_addr;
  logic             r_err;

  logic [31:0] w_word;
  logic        w_illegal;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign in_ready  = !w_full;
  assign w_accept  = in_valid && in_ready;
  // flush wins: the bundle presented with it is dropped silently
  assign w_push    = w_accept && !w_illegal && !flush;
  assign w_pop     = !w_empty && out_ready && !flush;

  assign out_valid   = !w_empty;
  assign out_word    = w_empty ? '0 : r_mem[r_rptr];
  assign out_addr    = r_addr;
  assign err_illegal = r_err;

  // Field packing per instruction format; flags types 6/7 and odd B/J offsets
  always_comb begin
    w_word    = '0;
    w_illegal = 1'b0;
    case (in_type)
      T_R: w_word = {in_func7, in_rs2, in_rs1, in_func3, in_rd, 7'b0110011};
      T_I: begin
        // shift-immediates carry func7 in the upper bits and a 5-bit shamt
        if (in_func3 == 3'b001 || in_func3 == 3'b101)
          w_word = {in_func7, in_imm[4:0], in_rs1, in_func3, in_rd, 7'b0010011};
        else
          w_word = {in_imm[11:0], in_rs1, in_func3, in_rd, 7'b0010011};
      end
      T_S: w_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], 7'b0100011};
      T_B: begin
        w_word    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                     in_imm[4:1], in_imm[11], 7'b1100011};
        w_illegal = in_imm[0];
      end
      T_U: w_word = {in_imm[31:12], in_rd, 7'b0010111};
      T_J: begin
        w_word    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                     in_rd, 7'b1101111};
        w_illegal = in_imm[0];
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

  // Pointers, occupancy, address counter and illegal-bundle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_addr  <= BASE_ADDR;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_addr  <= BASE_ADDR;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
        r_addr <= r_addr + ADDR_W'(4);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/riscv_inst_encoder.md
Name: riscv_inst_encoder

Overview:
- Inverse of the testbench instruction decode types: packs RV32I instruction fields (R/I/S/B/U/J formats) into 32-bit instruction words.
- Buffers encoded words in a small FIFO and streams them, with sequential word addresses, to an instruction-memory loader through a valid/ready port.
- Used by the environment to build program images from sequence-item fields.

Parameters:
- FIFO_DEPTH, 4, encoded-word buffer depth; power of two, >=2.
- ADDR_W, 32, width of out_addr.
- BASE_ADDR, 32'h0000_0000, address of the first word after reset or flush; multiple of 4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of FIFO and address counter.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_type  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_func3  in  3  func3 field.
- in_func7  in  7  func7 field (R; I shifts).
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  immediate; the low bits are used per format.
- out_valid  out  1  encoded word available.
- out_ready  in  1  downstream accepts the word.
- out_word  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_word.
- err_illegal  out  1  one-cycle pulse on a dropped bundle.

Behaviour:
Reset and handshake
- Reset (rst_n low, asynchronous):
  - FIFO empty; address counter = BASE_ADDR; err_illegal = 0.
  - in_ready = 1, out_valid = 0, out_word = 0, out_addr = BASE_ADDR.
- Accept when in_valid & in_ready. in_ready = !full; full means FIFO_DEPTH entries.
- A push and a pop in the same cycle while full is not allowed, because in_ready is already low.

Encoding (combinational, written on accept)
- R: {func7, rs2, rs1, func3, rd, 7'b0110011}.
- I: {imm[11:0], rs1, func3, rd, 7'b0010011}.
  - Exception: when func3 is 001 or 101, bits [31:25] = func7 and bits [24:20] = imm[4:0].
- S: {imm[11:5], rs2, rs1, func3, imm[4:0], 7'b0100011}.
- B: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], 7'b1100011}.
- U: {imm[31:12], rd, 7'b0010111}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}.
- Immediate bits outside each format are ignored; there is no range check.

Illegal bundles
- A bundle is illegal when in_type is 6 or 7, or when in_type is B or J and imm[0] = 1.
- An illegal bundle is accepted (the handshake completes) but is not pushed.
- err_illegal = 1 in the cycle after the accept, for one cycle.
- The address counter is unaffected.

Latency and ordering
- A word accepted at edge N is visible on out_valid/out_word after edge N (registered FIFO).
- FIFO order is preserved.
- out_word and out_addr hold stable while out_valid & !out_ready.

Address counter
- out_addr is the current counter value.
- The counter advances by 4 on each pop (out_valid & out_ready).
- It wraps modulo 2^ADDR_W.

Boundary conditions
- Simultaneous push and pop when neither full nor empty: occupancy is unchanged.
- Push into empty with no pop: out_valid rises the next cycle.
- flush: takes priority over push and pop in the same cycle.
  - FIFO emptied; counter = BASE_ADDR.
  - An input bundle presented that cycle is dropped without err_illegal.
- Reset mid-stream: all buffered words are lost.

Test Plan:
- ADDI x1,x0,5 (I, f3=000, rd=1, rs1=0, imm=5); ADD x3,x1,x2 (R, f7=0, f3=000, rd=3, rs1=1, rs2=2) -> out_word 0x00500093 at addr 0x0, then 0x002081B3 at addr 0x4.
- SW x2,8(x1) (S, f3=010, rs1=1, rs2=2, imm=8) -> 0x0020A423. BEQ x1,x2,+8 (B, imm=8) -> 0x00208463.
- JAL x1,+16 (J, rd=1, imm=16) -> 0x010000EF. SRAI x5,x6,3 (I, f3=101, f7=0x20, imm=3) -> 0x40335293.
- in_type=7, then B with imm=9 -> two err_illegal pulses, no out_valid, next legal word still at addr 0x0.
- out_ready held 0 while pushing 5 bundles with FIFO_DEPTH=4 -> in_ready falls after the 4th accept. Release out_ready -> words drain in order at 0x0, 0x4, 0x8, 0xC; 5th accepted, emitted at 0x10.
- Assert flush with 3 words buffered and in_valid=1 -> out_valid=0 the next cycle, the next word is emitted at BASE_ADDR, no err_illegal. Separately, drop rst_n mid-stream -> outputs return to reset values immediately.
